// File: rtl/glbl_pkg.sv
// glbl_pkg: shared startup-sequencer state type and counter sizing helper
package glbl_pkg;
    typedef enum logic [1:0] {ST_ROC, ST_TOC, ST_DONE} state_t;
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/glbl_cnt.sv
// glbl_cnt: loadable down-counter with last/zero flags for the startup sequencer
module glbl_cnt #(
    parameter int W    = 4,
    parameter int INIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic         last,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n)   cnt <= W'(INIT);
        else if (ld)  cnt <= ld_val;
        else if (dec) cnt <= cnt - 1'b1;
    end
    assign last = cnt == W'(1);
    assign zero = cnt == '0;
endmodule

// File: rtl/glbl_ctrl.sv
// glbl_ctrl: power-on style startup sequencer driving gsr/prld, gts and done
module glbl_ctrl
    import glbl_pkg::*;
#(
    parameter int ROC_CYCLES = 10,
    parameter int TOC_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic gsr,
    output logic prld,
    output logic gts,
    output logic done,
    output logic busy
);
    localparam int W       = cnt_width(ROC_CYCLES, TOC_CYCLES);
    localparam bit HAS_TOC = TOC_CYCLES > 0;
    state_t         state, state_nxt;
    logic           ld, dec, last, zero;
    logic [W-1:0]   ld_val;
    glbl_cnt #(.W(W), .INIT(ROC_CYCLES)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (ld),
        .ld_val (ld_val),
        .dec    (dec),
        .last   (last),
        .zero   (zero)
    );
    // the zero guard keeps the counter parked at 0 in DONE instead of wrapping
    assign dec = !ld && !zero;
    always_comb begin
        state_nxt = state;
        ld        = restart;
        ld_val    = W'(ROC_CYCLES);
        if (restart) begin
            state_nxt = ST_ROC;
        end else if (last && state == ST_ROC && HAS_TOC) begin
            state_nxt = ST_TOC;
            ld        = 1'b1;
            ld_val    = W'(TOC_CYCLES);
        end else if (last && state != ST_DONE) begin
            state_nxt = ST_DONE;
        end
    end
    // outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ROC;
            gsr   <= 1'b1;
            gts   <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            gsr   <= state_nxt == ST_ROC;
            gts   <= state_nxt != ST_DONE;
            done  <= state_nxt == ST_DONE;
        end
    end
    assign prld = gsr;
    assign busy = ~done;
endmodule

// File: tb/tb_glbl_ctrl.sv
// tb_glbl_ctrl: scoreboard bench for three glbl_ctrl configurations sharing one stimulus
module tb_glbl_ctrl;
    localparam int N = 3;
    localparam int ROC [N] = '{10, 4, 1};
    localparam int TOC [N] = '{0, 3, 0};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    wire [4:0] o [N];
    int n_chk = 0;
    int n_fail = 0;
    int k [N] = '{0, 0, 0};
    int n_gsr [N];
    int n_gts [N];
    int first_done [N];
    int idx;
    logic [5*N-1:0] q [$];
    always #5 clk = ~clk;
    for (genvar g = 0; g < N; g++) begin : g_dut
        glbl_ctrl #(.ROC_CYCLES(ROC[g]), .TOC_CYCLES(TOC[g])) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .restart (restart),
            .gsr     (o[g][4]),
            .prld    (o[g][3]),
            .gts     (o[g][2]),
            .done    (o[g][1]),
            .busy    (o[g][0])
        );
    end
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // k counts edges since the last start event; outputs follow from where k sits in the phases
    function automatic logic [4:0] exp_vec(input int roc, input int toc, input int kk);
        logic g, t;
        g = kk < roc;
        t = kk < roc + toc;
        return {g, g, t, !t, t};
    endfunction
    task automatic mark();
        idx = 0;
        for (int i = 0; i < N; i++) begin
            n_gsr[i] = 0;
            n_gts[i] = 0;
            first_done[i] = 0;
        end
    endtask
    task automatic cycle(input logic rn, input logic rs);
        logic [5*N-1:0] e;
        rst_n = rn;
        restart = rs;
        for (int i = 0; i < N; i++) begin
            k[i] = (!rn || rs) ? 0 : (k[i] < 4096 ? k[i] + 1 : k[i]);
            e[i*5 +: 5] = exp_vec(ROC[i], TOC[i], k[i]);
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        idx++;
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("dut%0d outs", i), {27'd0, o[i]}, {27'd0, e[i*5 +: 5]});
            if (o[i][4]) n_gsr[i]++;
            if (o[i][2]) n_gts[i]++;
            if (o[i][1] && first_done[i] == 0) first_done[i] = idx;
        end
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask
    initial begin
        mark();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        mark();
        cycle(1'b0, 1'b0);
        run(13);
        check_eq("rst gsr len d0", n_gsr[0], 10);
        check_eq("rst done at d0", first_done[0], 11);
        check_eq("rst gsr len d1", n_gsr[1], 4);
        check_eq("rst gts len d1", n_gts[1], 7);
        check_eq("rst done at d1", first_done[1], 8);
        check_eq("rst gsr len d2", n_gsr[2], 1);
        check_eq("rst done at d2", first_done[2], 2);
        mark();
        cycle(1'b1, 1'b1);
        run(11);
        check_eq("restart in done gsr", n_gsr[0], 10);
        check_eq("restart in done done", first_done[0], 11);
        cycle(1'b1, 1'b1);
        run(4);
        mark();
        cycle(1'b1, 1'b1);
        run(11);
        check_eq("mid-roc restart gsr", n_gsr[0], 10);
        check_eq("mid-roc restart done", first_done[0], 11);
        mark();
        cycle(1'b0, 1'b1);
        run(11);
        check_eq("rst+restart gsr", n_gsr[0], 10);
        check_eq("rst+restart done", first_done[0], 11);
        mark();
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1);
        check_eq("held restart gsr", n_gsr[0], 12);
        check_eq("held restart done", first_done[0], 0);
        run(12);
        cycle(1'b1, 1'b1);
        run(3);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        run(12);
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 11) == 0);
        run(16);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
